// File: rtl/one_to_eight_demux.sv
// Registered 1-to-8 stream demultiplexer: one producer word is routed to a single channel
// (or broadcast to all eight), each channel holding it in a one-entry valid/ready register.
module one_to_eight_demux #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [2:0]           in_sel,
    input  logic                 in_bcast,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [8*WIDTH-1:0]   out_data,
    output logic [7:0]           out_valid,
    input  logic [7:0]           out_ready,
    output logic [15:0]          xfer_count
);

    logic [7:0]       full_q;
    logic [7:0]       full_d;
    logic [WIDTH-1:0] data_q [8];
    logic [15:0]      count_q;
    logic [15:0]      count_d;

    logic [7:0]       can_load;
    logic [7:0]       target;
    logic [7:0]       load;
    logic [7:0]       drain;
    logic             accept;

    always_comb begin
        can_load = ~full_q | out_ready;
        target   = in_bcast ? 8'hFF : (8'h01 << in_sel);
        // Every targeted channel must be able to take the word; untargeted ones don't matter.
        in_ready = &(can_load | ~target);
        accept   = in_valid & in_ready;
        load     = accept ? target : 8'h00;
        drain    = full_q & out_ready;
        full_d   = (full_q & ~drain) | load;
        count_d  = accept ? count_q + 16'd1 : count_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q  <= 8'h00;
            count_q <= 16'h0000;
            for (int k = 0; k < 8; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            full_q  <= full_d;
            count_q <= count_d;
            for (int k = 0; k < 8; k++) begin
                if (load[k]) begin
                    data_q[k] <= in_data;
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int k = 0; k < 8; k++) begin
            out_data[k*WIDTH +: WIDTH] = data_q[k];
        end
    end

    assign out_valid  = full_q;
    assign xfer_count = count_q;

endmodule

// File: tb/tb_one_to_eight_demux.sv
// Bench for one_to_eight_demux: directed scenarios plus random and streaming traffic,
// all checked against a per-channel queue model of the holding registers.
module tb_one_to_eight_demux;

    localparam int unsigned W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [W-1:0]     in_data;
    logic [2:0]       in_sel;
    logic             in_bcast;
    logic             in_valid;
    logic             in_ready;
    logic [8*W-1:0]   out_data;
    logic [7:0]       out_valid;
    logic [7:0]       out_ready;
    logic [15:0]      xfer_count;

    always #5 clk = ~clk;

    one_to_eight_demux #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_bcast   (in_bcast),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .xfer_count (xfer_count)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [W-1:0] q [8][$];
    logic [W-1:0] last [8];
    int unsigned mcount = 0;
    int          drained [8];
    bit          known = 1'b0;
    bit          stalled = 1'b0;

    task automatic chk(input string tag, input logic [8*W-1:0] obs, input logic [8*W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] sel, input logic bc,
                         input logic [W-1:0] d, input logic [7:0] ordy);
        in_valid  = v;
        in_sel    = sel;
        in_bcast  = bc;
        in_data   = d;
        out_ready = ordy;
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the model.
    task automatic tick();
        logic [7:0]   can;
        logic [7:0]   tgt;
        logic [7:0]   pop;
        logic [7:0]   ev;
        logic [8*W-1:0] ed;
        logic         exp_rdy;
        logic         acc;
        @(negedge clk);
        pop = 8'h00;
        for (int k = 0; k < 8; k++) begin
            ev[k]           = (q[k].size() != 0);
            ed[k*W +: W]    = last[k];
            can[k]          = (q[k].size() == 0) || out_ready[k];
        end
        tgt     = in_bcast ? 8'hFF : (8'h01 << in_sel);
        exp_rdy = in_bcast ? (&can) : can[in_sel];
        if (known) begin
            chk("out_valid", {{(8*W-8){1'b0}}, out_valid}, {{(8*W-8){1'b0}}, ev});
            chk("out_data", out_data, ed);
            chk("xfer_count", {{(8*W-16){1'b0}}, xfer_count},
                {{(8*W-16){1'b0}}, mcount[15:0]});
            chk("in_ready", {{(8*W-1){1'b0}}, in_ready}, {{(8*W-1){1'b0}}, exp_rdy});
            for (int k = 0; k < 8; k++) begin
                if (!rst && q[k].size() != 0 && out_ready[k]) begin
                    chk("drain_word", {{(7*W){1'b0}}, out_data[k*W +: W]},
                        {{(7*W){1'b0}}, q[k][0]});
                    pop[k] = 1'b1;
                end
            end
        end
        acc     = in_valid && exp_rdy;
        stalled = in_valid && !exp_rdy;
        @(posedge clk);
        #1;
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                q[k].delete();
                last[k] = '0;
            end
            mcount = 0;
            known  = 1'b1;
            stalled = 1'b0;
        end else if (known) begin
            for (int k = 0; k < 8; k++) begin
                if (pop[k]) begin
                    void'(q[k].pop_front());
                    drained[k]++;
                end
                if (acc && tgt[k]) begin
                    q[k].push_back(in_data);
                    last[k] = in_data;
                end
            end
            if (acc) mcount = (mcount + 1) % 65536;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 3'd0, 1'b0, '0, 8'h00);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [W-1:0] word;
        int           d0;
        for (int k = 0; k < 8; k++) drained[k] = 0;
        rst = 1'b0;
        drive(1'b0, 3'd0, 1'b0, '0, 8'h00);

        // Reset and single routing
        do_reset();
        chk("rst_valid", {{(8*W-8){1'b0}}, out_valid}, '0);
        chk("rst_count", {{(8*W-16){1'b0}}, xfer_count}, '0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'(i), 1'b0, 32'h100 + 32'(i), 8'h00);
            tick();
        end
        drive(1'b0, 3'd0, 1'b0, '0, 8'h00);
        chk("route_valid", {{(8*W-8){1'b0}}, out_valid}, {{(8*W-8){1'b0}}, 8'hFF});
        for (int k = 0; k < 8; k++) begin
            chk("route_slice", {{(7*W){1'b0}}, out_data[k*W +: W]},
                {{(7*W){1'b0}}, 32'h100 + 32'(k)});
        end
        chk("route_count", {{(8*W-16){1'b0}}, xfer_count}, {{(8*W-16){1'b0}}, 16'd8});

        // Backpressure on one channel only
        do_reset();
        drive(1'b1, 3'd3, 1'b0, 32'hAAAA, 8'h00);
        tick();
        drive(1'b1, 3'd3, 1'b0, 32'hBBBB, 8'h00);
        #1;
        chk("bp_ready3", {{(8*W-1){1'b0}}, in_ready}, '0);
        tick();
        chk("bp_slice3", {{(7*W){1'b0}}, out_data[3*W +: W]}, {{(7*W){1'b0}}, 32'hAAAA});
        drive(1'b1, 3'd5, 1'b0, 32'h5555, 8'h00);
        #1;
        chk("bp_ready5", {{(8*W-1){1'b0}}, in_ready}, {{(8*W-1){1'b0}}, 1'b1});
        tick();

        // Drain and reload in the same cycle
        do_reset();
        drive(1'b1, 3'd2, 1'b0, 32'h11, 8'h00);
        tick();
        drive(1'b1, 3'd2, 1'b0, 32'h22, 8'h04);
        #1;
        chk("dr_ready", {{(8*W-1){1'b0}}, in_ready}, {{(8*W-1){1'b0}}, 1'b1});
        d0 = drained[2];
        tick();
        drive(1'b0, 3'd0, 1'b0, '0, 8'h00);
        chk("dr_valid2", {{(8*W-1){1'b0}}, out_valid[2]}, {{(8*W-1){1'b0}}, 1'b1});
        chk("dr_slice2", {{(7*W){1'b0}}, out_data[2*W +: W]}, {{(7*W){1'b0}}, 32'h22});
        chk("dr_seen_once", 256'(drained[2] - d0), 256'd1);

        // Broadcast blocked by one full channel, then released
        do_reset();
        drive(1'b1, 3'd6, 1'b0, 32'h1234, 8'h00);
        tick();
        drive(1'b1, 3'd0, 1'b1, 32'hCAFE, 8'h00);
        #1;
        chk("bc_blocked", {{(8*W-1){1'b0}}, in_ready}, '0);
        tick();
        drive(1'b1, 3'd0, 1'b1, 32'hCAFE, 8'h40);
        #1;
        chk("bc_ready", {{(8*W-1){1'b0}}, in_ready}, {{(8*W-1){1'b0}}, 1'b1});
        tick();
        drive(1'b0, 3'd0, 1'b0, '0, 8'h00);
        chk("bc_valid", {{(8*W-8){1'b0}}, out_valid}, {{(8*W-8){1'b0}}, 8'hFF});
        chk("bc_data", out_data, {8{32'hCAFE}});
        chk("bc_count", {{(8*W-16){1'b0}}, xfer_count}, {{(8*W-16){1'b0}}, 16'd2});

        // Random traffic; the producer holds its word while stalled
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if (!stalled) begin
                word = $urandom;
                drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      ($urandom_range(0, 7) == 0), word, 8'($urandom));
            end else begin
                out_ready = 8'($urandom);
            end
            tick();
        end

        // Full-rate streaming through the counter wrap
        do_reset();
        for (int i = 0; i < 65537; i++) begin
            drive(1'b1, 3'(i % 8), 1'b0, $urandom, 8'hFF);
            tick();
        end
        drive(1'b0, 3'd0, 1'b0, '0, 8'hFF);
        chk("wrap_count", {{(8*W-16){1'b0}}, xfer_count}, {{(8*W-16){1'b0}}, 16'd1});
        tick();

        // Reset wins over a simultaneous accept
        do_reset();
        drive(1'b1, 3'd0, 1'b0, 32'hA0, 8'h00);
        tick();
        drive(1'b1, 3'd4, 1'b0, 32'hA4, 8'h00);
        tick();
        rst = 1'b1;
        drive(1'b1, 3'd1, 1'b0, 32'hA1, 8'h00);
        tick();
        rst = 1'b0;
        drive(1'b0, 3'd0, 1'b0, '0, 8'h00);
        chk("mid_rst_valid", {{(8*W-8){1'b0}}, out_valid}, '0);
        chk("mid_rst_data", out_data, '0);
        chk("mid_rst_count", {{(8*W-16){1'b0}}, xfer_count}, '0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/one_to_eight_demux.md
# one_to_eight_demux

Registered 1-to-8 stream demultiplexer for WIDTH-bit words. It is the distribution end of the 8-to-1 mux path: one producer stream is routed by a 3-bit select onto one of eight output channels, or broadcast to all eight. Each output channel has a one-entry holding register with a valid/ready handshake, so backpressure on one channel stalls only words addressed to that channel. A wrapping counter tracks accepted input words.

## Interface
Parameters:
- WIDTH, 32, data word width per channel

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous and active-high
- in_data  input  WIDTH  input word
- in_sel  input  3  destination channel index, 0..7
- in_bcast  input  1  1 = write the word to all 8 channels; in_sel is ignored
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts the word this cycle (combinational)
- out_data  output  8*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- out_valid  output  8  per-channel word present
- out_ready  input  8  per-channel consumer accepts
- xfer_count  output  16  number of accepted input words, wraps modulo 2^16

## Operation
- Per-channel state: full[k] (drives out_valid[k]) and data register d[k] (drives out_data slice k).
- can_load[k] = !full[k] || out_ready[k]. A full register that drains in the same cycle may be reloaded.
- in_ready:
  - in_bcast=0: can_load[in_sel].
  - in_bcast=1: AND of can_load[0..7].
- Input accept = in_valid && in_ready.
- On accept with in_bcast=0: d[in_sel] <= in_data, full[in_sel] <= 1.
- On accept with in_bcast=1: every d[k] <= in_data, every full[k] <= 1.
- Output drain: out_valid[k] && out_ready[k]. Without a reload of the same channel that cycle, full[k] <= 0.
- Simultaneous drain and reload of channel k: full[k] stays 1 and d[k] takes the new word. No bubble and no loss.
- Channels not addressed and not drained hold their state.
- out_data[k] holds its last loaded value when out_valid[k]=0. The value is not cleared and only has meaning when out_valid[k]=1.
- xfer_count increments by exactly 1 per accepted input word, including broadcasts. It wraps from 0xFFFF to 0x0000.
- in_sel and in_data are ignored when in_valid=0. in_ready may still toggle with in_sel.
- Reset values (synchronous, rst=1 at the edge):
  - all full[k] = 0, so out_valid = 8'h00
  - out_data = 0
  - xfer_count = 0
- Reset has priority over every accept and drain in the same cycle. Words held mid-operation are discarded.

## Timing
- Latency: a word accepted at edge N is visible on out_data/out_valid after edge N, so 1 cycle.
- Throughput: 1 word/cycle for a channel whose consumer holds out_ready=1. Routing to different channels on consecutive cycles is also 1 word/cycle.
- in_ready is combinational from in_sel, in_bcast, full, and out_ready. There is no combinational path from in_data.
- out_valid and out_data are registered only.
- The producer must hold in_data, in_sel, and in_bcast stable while in_valid=1 && in_ready=0.
- The consumer may assert out_ready independent of out_valid. out_ready with out_valid=0 has no effect.
- In the first cycle after rst is released, out_valid=0. in_ready=1 for any in_sel and for broadcast.

## Test plan
- Reset and single routing: rst high 2 cycles, then out_valid=00 and xfer_count=0. Send in_data=i+0x100 with in_sel=i, i=0..7, out_ready=00. Required: after 8 cycles out_valid=FF, each slice k=0x100+k, xfer_count=8.
- Backpressure: fill channel 3 (0xAAAA) with out_ready[3]=0, then offer in_sel=3 in_data=0xBBBB. Required: in_ready=0 and slice 3 stays 0xAAAA. Also offer in_sel=5 in the same situation: in_ready=1.
- Drain plus reload: channel 2 full with 0x11 and out_ready[2]=1 while 0x22 is offered to in_sel=2. Required: in_ready=1; next cycle out_valid[2]=1 with 0x22; consumer saw 0x11 exactly once.
- Broadcast: channel 6 full with out_ready[6]=0, in_bcast=1, in_data=0xCAFE. Required: in_ready=0. Raise out_ready[6]: accepted; next cycle out_valid=FF and all slices 0xCAFE; xfer_count increments by 1.
- Streaming and wrap: out_ready=FF, in_valid held 1 with in_sel cycling 0..7 for 65537 words. Required: no stall cycles, every word delivered once in order per channel, xfer_count=1.
- Reset mid-operation: channels 0, 4 full and rst asserted in a cycle that also has an accept to channel 1. Required: next cycle out_valid=00, out_data=0, xfer_count=0.
